// File: rtl/ctrl_unit_core.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_unit_core
// Description : Microcoded control unit of the 4-bit processor. Holds a
//               16x8 program store, a program counter and the jump logic.
//               Data-path words are streamed to the datapath on `instr`;
//               flow-control words (ctl=1) are evaluated locally and
//               replaced by a NOP (8'h00) on `instr`.
//
//               Instruction word: [7] imm-drive, [6:5] op, [4] ctl,
//               [3:0] imm.
//
// Ports       : clk      - single clock, rising edge
//               rst      - synchronous, active-high reset
//               state    - 0 = load/idle mode, 1 = run mode
//               load     - store write enable (load mode only)
//               instr_i  - instruction word to store
//               instr    - registered instruction to the datapath
//               bus      - shared 4-bit tri-state data bus; bus[0] is the
//                          zero flag sampled by conditional jumps
//
// Build option: CTRL_HALT_EN - when defined, op 11 with ctl=1 halts the
//               unit (pc frozen, NOP output) until rst or state=0.
//               When undefined, that word behaves as a NOP.
//
// Revision    : 1.0 - initial release
// ============================================================================

module ctrl_unit_core #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8,
    parameter int DATA_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               state,
    input  logic               load,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [INSTR_W-1:0] instr,
    inout  wire  [DATA_W-1:0]  bus
);

    localparam int c_DEPTH   = 2 ** ADDR_W;
    localparam int c_BIT_DRV = 7;
    localparam int c_BIT_CTL = 4;
    localparam int c_OP_HI   = 6;
    localparam int c_OP_LO   = 5;

    localparam logic [INSTR_W-1:0] c_NOP = '0;

    localparam logic [1:0] c_OP_JMP = 2'b00;
    localparam logic [1:0] c_OP_JNZ = 2'b01;
    localparam logic [1:0] c_OP_JZ  = 2'b10;
    localparam logic [1:0] c_OP_HLT = 2'b11;

    // Program store: deliberately has no reset so a loaded program
    // survives a reset pulse.
    logic [INSTR_W-1:0] r_mem [0:c_DEPTH-1];

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_wptr;
    logic [INSTR_W-1:0] r_instr;

    logic [INSTR_W-1:0] w_word;
    logic [1:0]         w_op;
    logic               w_ctl;
    logic [DATA_W-1:0]  w_imm;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_pc_imm;
    logic               w_zero;
    logic               w_bus_drive;
    logic               w_unused_bus;

    assign w_word   = r_mem[r_pc];
    assign w_op     = w_word[c_OP_HI:c_OP_LO];
    assign w_ctl    = w_word[c_BIT_CTL];
    assign w_imm    = w_word[DATA_W-1:0];
    assign w_pc_inc = r_pc + 1'b1;
    assign w_pc_imm = ADDR_W'(w_imm);
    assign w_zero   = bus[0];

    // Only flag bit 0 is ever read from the bus.
    assign w_unused_bus = ^bus[DATA_W-1:1];

    // Immediate drive is tied to data words only; flow-control words never
    // drive, so the flag sampled by a jump always comes from outside.
    assign w_bus_drive = state && w_word[c_BIT_DRV] && !w_ctl;
    assign bus         = w_bus_drive ? w_imm : {DATA_W{1'bz}};

    assign instr = r_instr;

    // ------------------------------------------------------------------
    // Program store write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && !state && load) begin
            r_mem[r_wptr] <= instr_i;
        end
    end

`ifdef CTRL_HALT_EN
    logic r_halted;
`endif

    // ------------------------------------------------------------------
    // Sequencer: pc, write pointer, instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_wptr  <= '0;
            r_instr <= c_NOP;
`ifdef CTRL_HALT_EN
            r_halted <= 1'b0;
`endif
        end else if (!state) begin
            // Load/idle: park at address 0 so the next run starts there.
            r_pc    <= '0;
            r_instr <= c_NOP;
`ifdef CTRL_HALT_EN
            r_halted <= 1'b0;
`endif
            if (load) begin
                r_wptr <= r_wptr + 1'b1;
            end
        end else begin
`ifdef CTRL_HALT_EN
            if (r_halted) begin
                r_instr <= c_NOP;
            end else
`endif
            if (!w_ctl) begin
                r_instr <= w_word;
                r_pc    <= w_pc_inc;
            end else begin
                r_instr <= c_NOP;
                case (w_op)
                    c_OP_JMP: r_pc <= w_pc_imm;
                    c_OP_JNZ: r_pc <= w_zero ? w_pc_inc : w_pc_imm;
                    c_OP_JZ:  r_pc <= w_zero ? w_pc_imm : w_pc_inc;
                    c_OP_HLT: begin
`ifdef CTRL_HALT_EN
                        r_halted <= 1'b1;
`else
                        r_pc <= w_pc_inc;
`endif
                    end
                    default:  r_pc <= w_pc_inc;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_unit_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_unit_core
// Description : Directed self-checking bench for ctrl_unit_core. Loads a
//               program, runs it with both flag values, exercises the
//               immediate bus drive, JZ, load-while-running, store wrap and
//               the op-11 word (halt when CTRL_HALT_EN is defined, NOP
//               otherwise).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_ctrl_unit_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       state;
    logic       load;
    logic [7:0] instr_i;
    wire  [7:0] instr;
    wire  [3:0] bus;

    // Bench side of the shared bus; released whenever the DUT should drive.
    logic       r_tb_bus_en;
    logic [3:0] r_tb_bus_val;
    assign bus = r_tb_bus_en ? r_tb_bus_val : 4'bzzzz;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_unit_core #(
        .ADDR_W  (4),
        .INSTR_W (8),
        .DATA_W  (4)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .state   (state),
        .load    (load),
        .instr_i (instr_i),
        .instr   (instr),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] prog   [16];
        logic [7:0] seq_a  [9];
        logic [7:0] seq_b  [9];

        prog  = '{8'h29, 8'h42, 8'h0C, 8'h03, 8'h0B, 8'h33, 8'h0E, 8'h02,
                  8'h4F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        // JNZ at addr 5 taken (flag=0): loop back to addr 3.
        seq_a = '{8'h29, 8'h42, 8'h0C, 8'h03, 8'h0B, 8'h00, 8'h03, 8'h0B, 8'h00};
        // JNZ at addr 5 not taken (flag=1): fall through.
        seq_b = '{8'h29, 8'h42, 8'h0C, 8'h03, 8'h0B, 8'h00, 8'h0E, 8'h02, 8'h4F};

        rst          = 1'b1;
        state        = 1'b0;
        load         = 1'b0;
        instr_i      = 8'h00;
        r_tb_bus_en  = 1'b1;
        r_tb_bus_val = 4'hA;

        // Reset
        step();
        check("rst_instr", instr, 8'h00);
        check("rst_bus_released", {4'h0, bus}, 8'h0A);
        rst = 1'b0;

        // Fill all 16 addresses; wptr wraps back to 0.
        for (int i = 0; i < 16; i++) begin
            load    = 1'b1;
            instr_i = prog[i];
            step();
        end
        load = 1'b0;
        check("load_mode_instr", instr, 8'h00);

        // Run with flag = 0: JNZ taken.
        r_tb_bus_val = 4'h0;
        state        = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("jnz_taken[%0d]", i), instr, seq_a[i]);
        end
        state = 1'b0;
        step();
        check("stop_mid_run", instr, 8'h00);

        // Run with flag = 1: JNZ falls through; load held high is ignored.
        r_tb_bus_val = 4'h1;
        state        = 1'b1;
        load         = 1'b1;
        instr_i      = 8'hC7;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("jnz_fall[%0d]", i), instr, seq_b[i]);
        end
        load  = 1'b0;
        state = 1'b0;
        step();
        check("stop_after_fall", instr, 8'h00);

        // Restart from pc=0: addr 0 must still hold the original word.
        state = 1'b1;
        step();
        check("load_in_run_ignored", instr, 8'h29);
        state = 1'b0;
        step();

        // 17th word lands on addr 0; then addr 1 = JZ 4, addr 2 = op-11 word.
        load    = 1'b1;
        instr_i = 8'h85;
        step();
        instr_i = 8'h54;
        step();
        instr_i = 8'h70;
        step();
        load = 1'b0;

        // Run A: immediate drive, then JZ taken (flag=1).
        r_tb_bus_en = 1'b0;
        state       = 1'b1;
        #1;
        check("imm_drive_bus", {4'h0, bus}, 8'h05);
        step();
        check("wrap_word_addr0", instr, 8'h85);
        r_tb_bus_en  = 1'b1;
        r_tb_bus_val = 4'h1;
        #1;
        check("imm_bus_released", {4'h0, bus}, 8'h01);
        step();
        check("jz_taken_nop", instr, 8'h00);
        step();
        check("jz_target", instr, 8'h0B);
        state = 1'b0;
        step();
        check("stop_run_a", instr, 8'h00);

        // Run B: JZ not taken (flag=0), then the op-11 word.
        r_tb_bus_en = 1'b0;
        state       = 1'b1;
        step();
        check("run_b_first", instr, 8'h85);
        r_tb_bus_en  = 1'b1;
        r_tb_bus_val = 4'h0;
        step();
        check("jz_fall_nop", instr, 8'h00);
        step();
        check("op11_nop", instr, 8'h00);
        step();
`ifdef CTRL_HALT_EN
        check("halt_hold_1", instr, 8'h00);
`else
        check("op11_next", instr, 8'h03);
`endif
        step();
`ifdef CTRL_HALT_EN
        check("halt_hold_2", instr, 8'h00);
`else
        check("op11_next2", instr, 8'h0B);
`endif
        state = 1'b0;
        step();
        check("stop_run_b", instr, 8'h00);
        r_tb_bus_en = 1'b0;
        state       = 1'b1;
        step();
        check("resume_after_stop", instr, 8'h85);
        state       = 1'b0;
        r_tb_bus_en = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
